subtractor_param_seq: RTL and testbench



---
 rtl/subtractor_param_seq.sv | 145 ++++++++++++++
 tb/tb_subtractor_param_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/subtractor_param_seq.sv
// Sequential unsigned subtractor: forms {1'b0,a} - {1'b0,b} one CHUNK_WIDTH slice per cycle,
// LSB first with a ripple borrow, and presents a selected slice of the difference.
module subtractor_param_seq #(
  parameter int DATA_IN_WIDTH  = 8,
  parameter int DATA_OUT_WIDTH = 8,
  parameter int CHUNK_WIDTH    = 4,
  parameter bit TAKE_MSB       = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_IN_WIDTH-1:0]  data_in_1,
  input  logic [DATA_IN_WIDTH-1:0]  data_in_2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_OUT_WIDTH-1:0] data_out,
  output logic                      borrow_out
);

  localparam int NUM_CHUNKS = DATA_IN_WIDTH / CHUNK_WIDTH;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic                      borrow_q, borrow_d;
  logic [DATA_IN_WIDTH-1:0]  a_q, a_d;
  logic [DATA_IN_WIDTH-1:0]  b_q, b_d;
  logic [DATA_IN_WIDTH:0]    diff_q, diff_d;
  logic                      out_valid_q, out_valid_d;
  logic [DATA_OUT_WIDTH-1:0] data_out_q, data_out_d;
  logic                      borrow_out_q, borrow_out_d;

  logic [CHUNK_WIDTH-1:0]    a_chunk;
  logic [CHUNK_WIDTH-1:0]    b_chunk;
  logic [CHUNK_WIDTH:0]      chunk_sub;
  logic                      last_chunk;

  // MSB-aligned or LSB-aligned truncation of the full-width difference.
  function automatic logic [DATA_OUT_WIDTH-1:0] select_slice(input logic [DATA_IN_WIDTH:0] diff);
    if (TAKE_MSB) begin
      return diff[DATA_IN_WIDTH -: DATA_OUT_WIDTH];
    end else begin
      return diff[DATA_OUT_WIDTH-1:0];
    end
  endfunction

  // Current chunk difference; the top bit of the (CHUNK_WIDTH+1)-bit result is the outgoing borrow.
  always_comb begin
    a_chunk    = a_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH];
    b_chunk    = b_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH];
    chunk_sub  = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK_WIDTH{1'b0}}, borrow_q};
    last_chunk = (idx_q == IDX_W'(NUM_CHUNKS - 1));
  end

  // Next-state and datapath update for the IDLE/CALC/DONE sequencer.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    borrow_d     = borrow_q;
    a_d          = a_q;
    b_d          = b_q;
    diff_d       = diff_q;
    out_valid_d  = out_valid_q;
    data_out_d   = data_out_q;
    borrow_out_d = borrow_out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = CALC;
          a_d      = data_in_1;
          b_d      = data_in_2;
          idx_d    = '0;
          borrow_d = 1'b0;
          diff_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        diff_d[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH] = chunk_sub[CHUNK_WIDTH-1:0];
        borrow_d = chunk_sub[CHUNK_WIDTH];
        idx_d    = idx_q + IDX_W'(1);
        if (last_chunk) begin
          diff_d[DATA_IN_WIDTH] = chunk_sub[CHUNK_WIDTH];
          state_d      = DONE;
          out_valid_d  = 1'b1;
          data_out_d   = select_slice(diff_d);
          borrow_out_d = chunk_sub[CHUNK_WIDTH];
        end else begin
          state_d = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      borrow_q     <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      diff_q       <= '0;
      out_valid_q  <= 1'b0;
      data_out_q   <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      borrow_q     <= borrow_d;
      a_q          <= a_d;
      b_q          <= b_d;
      diff_q       <= diff_d;
      out_valid_q  <= out_valid_d;
      data_out_q   <= data_out_d;
      borrow_out_q <= borrow_out_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign data_out   = data_out_q;
  assign borrow_out = borrow_out_q;

endmodule

// File: tb/tb_subtractor_param_seq.sv
// Self-checking bench: four subtractor configurations checked against an arithmetic model
// of the difference, latency, handshake, back-pressure and reset abort.
module tb_subtractor_param_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] iv;
  logic [3:0] ordy;
  logic [3:0] ir;
  logic [3:0] ov;
  logic [3:0] bo;
  logic [7:0] a_arr [4];
  logic [7:0] b_arr [4];
  logic [7:0] dout  [4];

  int cmp_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  // Instance 0: C=4 MSB, 1: C=4 LSB, 2: C=1 LSB, 3: C=8 MSB
  for (genvar g = 0; g < 4; g++) begin : g_dut
    subtractor_param_seq #(
      .DATA_IN_WIDTH (8),
      .DATA_OUT_WIDTH(8),
      .CHUNK_WIDTH   ((g == 2) ? 1 : ((g == 3) ? 8 : 4)),
      .TAKE_MSB      ((g == 1 || g == 2) ? 1'b0 : 1'b1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .data_in_1 (a_arr[g]),
      .data_in_2 (b_arr[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .data_out  (dout[g]),
      .borrow_out(bo[g])
    );
  end

  function automatic int cw_of(input int i);
    case (i)
      2:       return 1;
      3:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic bit msb_of(input int i);
    return (i == 0 || i == 3);
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction on instance i; hold = cycles of back-pressure after out_valid
  task automatic run_op(input int i, input logic [7:0] x, input logic [7:0] y, input int hold);
    int d;
    int cyc;
    logic [7:0] exp_out;
    logic       exp_bor;
    d       = (int'(x) - int'(y) + 512) % 512;
    exp_out = msb_of(i) ? 8'(d / 2) : 8'(d % 256);
    exp_bor = (d >= 256);
    check_val("ready_idle", 32'(ir[i]), 32'd1);
    a_arr[i] = x;
    b_arr[i] = y;
    iv[i]    = 1'b1;
    @(posedge clk); #1;
    iv[i]    = 1'b0;
    a_arr[i] = 8'($urandom);
    b_arr[i] = 8'($urandom);
    cyc = 0;
    while (!ov[i] && cyc < 40) begin
      ordy[i] = 1'($urandom);
      @(posedge clk); #1;
      cyc++;
    end
    check_val("latency", 32'(cyc), 32'(8 / cw_of(i)));
    check_val("busy_ready", 32'(ir[i]), 32'd0);
    check_val("data_out", 32'(dout[i]), 32'(exp_out));
    check_val("borrow_out", 32'(bo[i]), 32'(exp_bor));
    for (int k = 0; k < hold; k++) begin
      ordy[i]  = 1'b0;
      iv[i]    = 1'($urandom);
      a_arr[i] = 8'($urandom);
      b_arr[i] = 8'($urandom);
      @(posedge clk); #1;
      check_val("bp_valid", 32'(ov[i]), 32'd1);
      check_val("bp_ready", 32'(ir[i]), 32'd0);
      check_val("bp_data", 32'(dout[i]), 32'(exp_out));
      check_val("bp_borrow", 32'(bo[i]), 32'(exp_bor));
    end
    iv[i]   = 1'b0;
    ordy[i] = 1'b1;
    @(posedge clk); #1;
    ordy[i] = 1'b0;
    check_val("post_valid", 32'(ov[i]), 32'd0);
    check_val("post_ready", 32'(ir[i]), 32'd1);
  endtask

  logic [7:0] dir_a [4] = '{8'hC8, 8'h05, 8'hFF, 8'h00};
  logic [7:0] dir_b [4] = '{8'h32, 8'h07, 8'hFF, 8'hFF};

  initial begin
    rst_n = 1'b0;
    iv    = 4'b0000;
    ordy  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = 8'h00;
      b_arr[i] = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check_val("rst_ready", 32'(ir[i]), 32'd1);
      check_val("rst_valid", 32'(ov[i]), 32'd0);
      check_val("rst_data", 32'(dout[i]), 32'd0);
      check_val("rst_borrow", 32'(bo[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors on every configuration
    for (int i = 0; i < 4; i++) begin
      for (int v = 0; v < 4; v++) begin
        run_op(i, dir_a[v], dir_b[v], 0);
      end
    end

    // Long back-pressure with input noise
    run_op(0, 8'h9A, 8'h3C, 10);

    // Reset one cycle after accept on the two slowest configurations
    a_arr[2] = 8'h77; b_arr[2] = 8'h11; iv[2] = 1'b1;
    a_arr[0] = 8'h77; b_arr[0] = 8'h11; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_val("abort_valid", 32'(ov[i]), 32'd0);
      check_val("abort_data", 32'(dout[i]), 32'd0);
      check_val("abort_borrow", 32'(bo[i]), 32'd0);
      check_val("abort_ready", 32'(ir[i]), 32'd1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check_val("no_stale_valid", 32'(ov[0] | ov[2]), 32'd0);
    end
    run_op(1, 8'h10, 8'h01, 0);
    run_op(2, 8'h10, 8'h01, 0);

    // Randomised operands and back-pressure
    for (int i = 0; i < 4; i++) begin
      for (int n = 0; n < 25; n++) begin
        run_op(i, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
